branch_predictor_unit: RTL



---
 rtl/branch_predictor_unit_if.sv | 30 +++
 rtl/branch_predictor_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/branch_predictor_unit_if.sv
// rtl/branch_predictor_unit_if.sv - fetch prediction and execute-stage update bundle
interface branch_predictor_unit_if #(
    parameter int XLEN      = 32,
    parameter int HIST_BITS = 2
);
    logic [XLEN-1:0]      f_pc;
    logic                 f_is_branch;
    logic [XLEN-1:0]      f_pred_pc;
    logic                 f_pred_taken;
    logic [HIST_BITS-1:0] f_hist;

    logic                 u_valid;
    logic [XLEN-1:0]      u_pc;
    logic [HIST_BITS-1:0] u_hist;
    logic                 u_taken;
    logic [XLEN-1:0]      u_target;
    logic                 u_mispredict;

    modport master (
        output f_pc, f_is_branch,
        input  f_pred_pc, f_pred_taken, f_hist,
        output u_valid, u_pc, u_hist, u_taken, u_target, u_mispredict
    );

    modport slave (
        input  f_pc, f_is_branch,
        output f_pred_pc, f_pred_taken, f_hist,
        input  u_valid, u_pc, u_hist, u_taken, u_target, u_mispredict
    );
endinterface

// File: rtl/branch_predictor_unit.sv
// rtl/branch_predictor_unit.sv - two-level adaptive branch predictor with tagged BTB and statistics
module branch_predictor_unit #(
    parameter int         XLEN      = 32,
    parameter int         IDX_BITS  = 8,
    parameter int         HIST_BITS = 2,
    parameter int         GSHARE    = 0,
    parameter logic [1:0] CNT_INIT  = 2'b01,
    parameter int         STAT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rstn,
    branch_predictor_unit_if.slave   bp,
    input  logic                     stats_clr,
    output logic                     init_busy,
    output logic [STAT_W-1:0]        stat_total,
    output logic [STAT_W-1:0]        stat_hit,
    output logic [STAT_W-1:0]        stat_miss
);

    localparam int NIDX   = 1 << IDX_BITS;
    localparam int ADDR_W = IDX_BITS + HIST_BITS;
    localparam int NCNT   = 1 << ADDR_W;
    localparam int NHIST  = 1 << HIST_BITS;
    localparam int TAG_W  = XLEN - IDX_BITS;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t               state;
    logic [IDX_BITS-1:0]  sweep_idx;
    logic [HIST_BITS-1:0] ghr;
    logic [HIST_BITS-1:0] ghr_next;

    logic [1:0]           cnt     [0:NCNT-1];
    logic [NIDX-1:0]      btb_v;
    logic [TAG_W-1:0]     btb_tag [0:NIDX-1];
    logic [XLEN-1:0]      btb_tgt [0:NIDX-1];

    function automatic logic [ADDR_W-1:0] cnt_addr(input logic [XLEN-1:0] pc,
                                                   input logic [HIST_BITS-1:0] h);
        if (GSHARE != 0)
            return pc[ADDR_W-1:0] ^ {{IDX_BITS{1'b0}}, h};
        else
            return {pc[IDX_BITS-1:0], h};
    endfunction

    // Prediction path: purely combinational off the pre-update table contents
    logic [IDX_BITS-1:0] f_idx;
    logic [1:0]          f_ctr;
    logic                f_hit;
    logic                f_taken;

    assign f_idx   = bp.f_pc[IDX_BITS-1:0];
    assign f_ctr   = cnt[cnt_addr(bp.f_pc, ghr)];
    assign f_hit   = btb_v[f_idx] && (btb_tag[f_idx] == bp.f_pc[XLEN-1:IDX_BITS]);
    assign f_taken = (state == S_RUN) && bp.f_is_branch && f_ctr[1] && f_hit;

    assign bp.f_pred_taken = f_taken;
    assign bp.f_pred_pc    = f_taken ? btb_tgt[f_idx] : bp.f_pc + XLEN'(1);
    assign bp.f_hist       = ghr;

    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign ghr_next = bp.u_taken;
        end else begin : g_histn
            assign ghr_next = {ghr[HIST_BITS-2:0], bp.u_taken};
        end
    endgenerate

    logic [IDX_BITS-1:0] u_idx;
    logic [ADDR_W-1:0]   u_addr;
    logic [1:0]          u_ctr;
    logic [1:0]          u_ctr_next;
    logic                upd_en;

    assign u_idx  = bp.u_pc[IDX_BITS-1:0];
    assign u_addr = cnt_addr(bp.u_pc, bp.u_hist);
    assign u_ctr  = cnt[u_addr];
    assign upd_en = (state == S_RUN) && bp.u_valid;

    always_comb begin
        u_ctr_next = u_ctr;
        if (bp.u_taken) begin
            if (u_ctr != 2'b11) u_ctr_next = u_ctr + 2'b01;
        end else begin
            if (u_ctr != 2'b00) u_ctr_next = u_ctr - 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= S_INIT;
            sweep_idx  <= '0;
            ghr        <= '0;
            init_busy  <= 1'b1;
            stat_total <= '0;
            stat_hit   <= '0;
            stat_miss  <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    // One BTB slot and its whole row of history counters per cycle
                    btb_v[sweep_idx] <= 1'b0;
                    for (int h = 0; h < NHIST; h++)
                        cnt[{sweep_idx, HIST_BITS'(h)}] <= CNT_INIT;
                    sweep_idx <= sweep_idx + IDX_BITS'(1);
                    if (sweep_idx == '1) begin
                        state     <= S_RUN;
                        init_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (bp.u_valid) begin
                        cnt[u_addr] <= u_ctr_next;
                        ghr         <= ghr_next;
                        if (bp.u_taken) btb_v[u_idx] <= 1'b1;
                    end
                    // Clear wins over a same-cycle increment so the invariant total == hit + miss holds
                    if (stats_clr) begin
                        stat_total <= '0;
                        stat_hit   <= '0;
                        stat_miss  <= '0;
                    end else if (bp.u_valid) begin
                        stat_total <= stat_total + STAT_W'(1);
                        if (bp.u_mispredict) stat_miss <= stat_miss + STAT_W'(1);
                        else                 stat_hit  <= stat_hit + STAT_W'(1);
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // Tag/target storage is qualified by btb_v, so it needs no reset
    always_ff @(posedge clk) begin
        if (rstn && upd_en && bp.u_taken) begin
            btb_tag[u_idx] <= bp.u_pc[XLEN-1:IDX_BITS];
            btb_tgt[u_idx] <= bp.u_target;
        end
    end

endmodule
